// File: rtl/rob_pkg.sv
// Shared ROB sizing constants and helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rob_pkg;

    // Default geometry of the reorder buffer
    localparam int DEF_ROB_ENTRY_NUM = 8;
    localparam int DEF_COMMON_W      = 32;

    // Architectural register index width
    localparam int DEST_W = 5;

    // Pointer width for a power-of-two entry count (at least one bit)
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Tag carries one extra bit so TAG_INVALID (== entry count) sits outside 0..N-1
    function automatic int tag_width(input int n);
        return ptr_width(n) + 1;
    endfunction

endpackage

// File: rtl/rob_broadcast_inf.sv
// Per-entry ROB state broadcast for reservation-station snooping.
// Latency: mirrors registered entry state, no added delay.
// Backpressure: none, purely observational.
interface rob_broadcast_inf #(
    parameter int N  = 8,
    parameter int TW = 4,
    parameter int W  = 32
);
    logic [N-1:0]         valid;
    logic [N-1:0]         ready;
    logic [N-1:0][TW-1:0] tag;
    logic [N-1:0][W-1:0]  val;

    modport out (output valid, output ready, output tag, output val);
    modport in  (input  valid, input  ready, input  tag, input  val);
endinterface

// File: rtl/rob.sv
// Reorder buffer: in-order allocate, out-of-order writeback, in-order single commit.
// Latency: writeback visible next cycle; commit pulse one cycle after head becomes ready.
// Backpressure: full stalls allocation (alloc_tag = TAG_INVALID); requests while full are dropped.
module rob
    import rob_pkg::*;
#(
    parameter int  ROB_ENTRY_NUM  = DEF_ROB_ENTRY_NUM,
    parameter int  COMMON_W       = DEF_COMMON_W,
    localparam int ROB_PTR_WIDTH  = ptr_width(ROB_ENTRY_NUM),
    localparam int INST_TAG_WIDTH = ROB_PTR_WIDTH + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alloc_req,
    input  logic [DEST_W-1:0]         alloc_dest,
    output logic [INST_TAG_WIDTH-1:0] alloc_tag,
    output logic                      full,
    input  logic [INST_TAG_WIDTH-1:0] wb_target,
    input  logic [COMMON_W-1:0]       wb_result,
    output logic                      commit_valid,
    output logic [DEST_W-1:0]         commit_dest,
    output logic [COMMON_W-1:0]       commit_val,
    rob_broadcast_inf.out             rob_info
);

    localparam logic [INST_TAG_WIDTH-1:0] TAG_INVALID = INST_TAG_WIDTH'(ROB_ENTRY_NUM);
    localparam logic [ROB_PTR_WIDTH:0]    COUNT_FULL  = (ROB_PTR_WIDTH + 1)'(ROB_ENTRY_NUM);

    typedef struct packed {
        logic                valid;
        logic                ready;
        logic [DEST_W-1:0]   dest;
        logic [COMMON_W-1:0] val;
    } rob_entry_t;

    rob_entry_t               entry_q [ROB_ENTRY_NUM];
    logic [ROB_PTR_WIDTH-1:0] head;
    logic [ROB_PTR_WIDTH-1:0] tail;
    logic [ROB_PTR_WIDTH:0]   count;

    logic                     alloc_fire;
    logic                     commit_fire;
    logic                     wb_hit;
    logic [ROB_PTR_WIDTH-1:0] wb_idx;

    // Full comes from the registered count, so a same-cycle commit cannot open a slot
    assign full       = (count == COUNT_FULL);
    assign alloc_tag  = full ? TAG_INVALID : {1'b0, tail};
    assign alloc_fire = alloc_req && !full;

    // Any tag with the extra bit set (including TAG_INVALID) is not a real entry
    assign wb_idx = wb_target[ROB_PTR_WIDTH-1:0];
    assign wb_hit = !wb_target[ROB_PTR_WIDTH] && entry_q[wb_idx].valid;

    // Head retires only on registered ready, giving a one-cycle writeback-to-commit latency
    assign commit_fire = entry_q[head].valid && entry_q[head].ready;

    // Head/tail/count bookkeeping and the registered commit port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            commit_valid <= 1'b0;
            commit_dest  <= '0;
            commit_val   <= '0;
        end else begin
            commit_valid <= commit_fire;
            if (commit_fire) begin
                commit_dest <= entry_q[head].dest;
                commit_val  <= entry_q[head].val;
                head        <= head + 1'b1;
            end
            if (alloc_fire) begin
                tail <= tail + 1'b1;
            end
            case ({alloc_fire, commit_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry state: writeback marks ready, commit frees head, allocation claims tail
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ROB_ENTRY_NUM; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            if (wb_hit) begin
                entry_q[wb_idx].ready <= 1'b1;
                entry_q[wb_idx].val   <= wb_result;
            end
            if (commit_fire) begin
                entry_q[head].valid <= 1'b0;
                entry_q[head].ready <= 1'b0;
            end
            // Tail is never a valid entry while allocation is allowed, so no overlap with the above
            if (alloc_fire) begin
                entry_q[tail].valid <= 1'b1;
                entry_q[tail].ready <= 1'b0;
                entry_q[tail].dest  <= alloc_dest;
                entry_q[tail].val   <= '0;
            end
        end
    end

    // Broadcast the registered entry state; tags are just the slot indices
    for (genvar i = 0; i < ROB_ENTRY_NUM; i++) begin : g_bcast
        assign rob_info.valid[i] = entry_q[i].valid;
        assign rob_info.ready[i] = entry_q[i].ready;
        assign rob_info.tag[i]   = INST_TAG_WIDTH'(i);
        assign rob_info.val[i]   = entry_q[i].val;
    end

endmodule

// File: tb/tb_rob.sv
// Directed bench for rob: vector table plus hand sequences for full, reset and wrap.
// Latency: inputs driven after an edge, outputs checked 1ns after the next edge.
// Backpressure: exercised through the full/ignored-allocation sequences.
module tb_rob;
    import rob_pkg::*;

    localparam int N  = 8;
    localparam int W  = 32;
    localparam int TW = tag_width(N);
    localparam int TI = N;
    localparam logic [TW-1:0] TINV = TW'(N);

    logic                clk = 1'b0;
    logic                rst;
    logic                alloc_req;
    logic [DEST_W-1:0]   alloc_dest;
    logic [TW-1:0]       alloc_tag;
    logic                full;
    logic [TW-1:0]       wb_target;
    logic [W-1:0]        wb_result;
    logic                commit_valid;
    logic [DEST_W-1:0]   commit_dest;
    logic [W-1:0]        commit_val;

    rob_broadcast_inf #(.N(N), .TW(TW), .W(W)) info ();

    rob #(.ROB_ENTRY_NUM(N), .COMMON_W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .alloc_req    (alloc_req),
        .alloc_dest   (alloc_dest),
        .alloc_tag    (alloc_tag),
        .full         (full),
        .wb_target    (wb_target),
        .wb_result    (wb_result),
        .commit_valid (commit_valid),
        .commit_dest  (commit_dest),
        .commit_val   (commit_val),
        .rob_info     (info)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic              a;
        logic [DEST_W-1:0] d;
        logic [TW-1:0]     wt;
        logic [W-1:0]      wr;
        logic              ecv;
        logic [DEST_W-1:0] ed;
        logic [W-1:0]      ev;
        logic              ef;
        logic [TW-1:0]     etag;
    } vec_t;

    function automatic vec_t mk(input int a, input int d, input int wt, input int wr,
                                input int cv, input int cd, input int cval,
                                input int f, input int tg);
        vec_t v;
        v.a    = a[0];
        v.d    = DEST_W'(d);
        v.wt   = TW'(wt);
        v.wr   = W'(wr);
        v.ecv  = cv[0];
        v.ed   = DEST_W'(cd);
        v.ev   = W'(cval);
        v.ef   = f[0];
        v.etag = TW'(tg);
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_req  = 1'b0;
        alloc_dest = '0;
        wb_target  = TINV;
        wb_result  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    vec_t tbl [17];

    // Random-phase model state
    int                qtag[$];
    int                cand[$];
    logic [DEST_W-1:0] mdest [N];
    logic [W-1:0]      mval  [N];
    bit                written [N];
    int                mtail;
    int                mcount;
    int                seq;
    int                t;
    int                pick;
    bit                do_alloc;
    bit                acc;
    logic [TW-1:0]     exp_tag;

    initial begin
        rst = 1'b0;
        idle();

        // Two-deep in-order commit, then out-of-order writeback, then stray writeback
        tbl[0]  = mk(1, 1,  TI, 0,       0, 0,  0, 0, 1);
        tbl[1]  = mk(1, 2,  TI, 0,       0, 0,  0, 0, 2);
        tbl[2]  = mk(1, 3,  TI, 0,       0, 0,  0, 0, 3);
        tbl[3]  = mk(0, 0,  0,  5,       0, 0,  0, 0, 3);
        tbl[4]  = mk(0, 0,  1,  6,       1, 1,  5, 0, 3);
        tbl[5]  = mk(0, 0,  2,  7,       1, 2,  6, 0, 3);
        tbl[6]  = mk(0, 0,  TI, 0,       1, 3,  7, 0, 3);
        tbl[7]  = mk(0, 0,  TI, 0,       0, 3,  7, 0, 3);
        tbl[8]  = mk(1, 10, TI, 0,       0, 3,  7, 0, 4);
        tbl[9]  = mk(1, 11, TI, 0,       0, 3,  7, 0, 5);
        tbl[10] = mk(0, 0,  4,  9,       0, 3,  7, 0, 5);
        tbl[11] = mk(0, 0,  TI, 0,       0, 3,  7, 0, 5);
        tbl[12] = mk(0, 0,  3,  4,       0, 3,  7, 0, 5);
        tbl[13] = mk(0, 0,  TI, 0,       1, 10, 4, 0, 5);
        tbl[14] = mk(0, 0,  TI, 0,       1, 11, 9, 0, 5);
        tbl[15] = mk(0, 0,  TI, 0,       0, 11, 9, 0, 5);
        tbl[16] = mk(0, 0,  5,  'hDEAD,  0, 11, 9, 0, 5);

        // Reset state
        do_reset();
        chk("rst_full",   64'(full),         64'd0);
        chk("rst_tag",    64'(alloc_tag),    64'd0);
        chk("rst_cv",     64'(commit_valid), 64'd0);
        chk("rst_cdest",  64'(commit_dest),  64'd0);
        chk("rst_cval",   64'(commit_val),   64'd0);
        chk("rst_valid",  64'(info.valid),   64'd0);
        chk("rst_ready",  64'(info.ready),   64'd0);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("bcast_tag%0d", i), 64'(info.tag[i]), 64'(i));
        end

        for (int i = 0; i < 17; i++) begin
            alloc_req  = tbl[i].a;
            alloc_dest = tbl[i].d;
            wb_target  = tbl[i].wt;
            wb_result  = tbl[i].wr;
            tick();
            chk($sformatf("row%0d_cv", i),    64'(commit_valid), 64'(tbl[i].ecv));
            chk($sformatf("row%0d_cdest", i), 64'(commit_dest),  64'(tbl[i].ed));
            chk($sformatf("row%0d_cval", i),  64'(commit_val),   64'(tbl[i].ev));
            chk($sformatf("row%0d_full", i),  64'(full),         64'(tbl[i].ef));
            chk($sformatf("row%0d_tag", i),   64'(alloc_tag),    64'(tbl[i].etag));
        end
        idle();
        chk("stray_wb_ready5", 64'(info.ready[5]), 64'd0);
        chk("stray_wb_valid5", 64'(info.valid[5]), 64'd0);
        tick();
        chk("stray_wb_no_commit", 64'(commit_valid), 64'd0);

        // Fill to full, ignored allocations, slot reuse after commit
        do_reset();
        for (int i = 0; i < N; i++) begin
            alloc_req  = 1'b1;
            alloc_dest = DEST_W'(20 + i);
            tick();
        end
        chk("fill_full",  64'(full),       64'd1);
        chk("fill_tag",   64'(alloc_tag),  64'(TINV));
        chk("fill_valid", 64'(info.valid), 64'hFF);
        alloc_dest = 5'd31;
        tick();
        chk("ninth_full", 64'(full),      64'd1);
        chk("ninth_tag",  64'(alloc_tag), 64'(TINV));
        wb_target = TW'(0);
        wb_result = 32'h100;
        tick();
        chk("full_wb_cv",     64'(commit_valid),  64'd0);
        chk("full_wb_ready0", 64'(info.ready[0]), 64'd1);
        chk("full_wb_val0",   64'(info.val[0]),   64'h100);
        chk("full_wb_full",   64'(full),          64'd1);
        wb_target = TINV;
        tick();
        chk("reuse_cv",     64'(commit_valid),  64'd1);
        chk("reuse_cdest",  64'(commit_dest),   64'd20);
        chk("reuse_cval",   64'(commit_val),    64'h100);
        chk("reuse_full",   64'(full),          64'd0);
        chk("reuse_tag",    64'(alloc_tag),     64'd0);
        chk("reuse_valid0", 64'(info.valid[0]), 64'd0);
        alloc_dest = 5'd30;
        tick();
        chk("refill_full",   64'(full),          64'd1);
        chk("refill_tag",    64'(alloc_tag),     64'(TINV));
        chk("refill_valid0", 64'(info.valid[0]), 64'd1);
        idle();

        // Asynchronous reset mid-stream while a commit pulse is high
        do_reset();
        for (int i = 0; i < 5; i++) begin
            alloc_req  = 1'b1;
            alloc_dest = DEST_W'(i + 1);
            tick();
        end
        idle();
        wb_target = TW'(0);
        wb_result = 32'h55;
        tick();
        idle();
        tick();
        chk("pre_rst_cv",    64'(commit_valid), 64'd1);
        chk("pre_rst_valid", 64'(info.valid),   64'h1E);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_cv",    64'(commit_valid), 64'd0);
        chk("async_rst_valid", 64'(info.valid),   64'd0);
        chk("async_rst_full",  64'(full),         64'd0);
        chk("async_rst_tag",   64'(alloc_tag),    64'd0);
        @(negedge clk);
        rst = 1'b1;
        alloc_req  = 1'b1;
        alloc_dest = 5'd9;
        tick();
        chk("post_rst_tag", 64'(alloc_tag),    64'd1);
        chk("post_rst_cv",  64'(commit_valid), 64'd0);
        idle();

        // Mixed alloc/writeback/commit with out-of-order writebacks and tag wrap
        do_reset();
        mtail  = 0;
        mcount = 0;
        seq    = 0;
        for (int i = 0; i < N; i++) written[i] = 1'b0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (cyc >= 40 && qtag.size() == 0) break;
            exp_tag = (mcount == N) ? TINV : TW'(mtail);
            chk("rand_alloc_tag", 64'(alloc_tag), 64'(exp_tag));
            do_alloc = (cyc < 40) && ($urandom_range(0, 3) != 0);
            acc      = do_alloc && (mcount < N);
            alloc_req  = do_alloc;
            alloc_dest = DEST_W'(seq);
            if (acc) begin
                mdest[mtail]   = DEST_W'(seq);
                written[mtail] = 1'b0;
            end
            cand.delete();
            foreach (qtag[k]) if (!written[qtag[k]]) cand.push_back(qtag[k]);
            wb_target = TINV;
            wb_result = '0;
            if (cand.size() > 0 && (cyc >= 40 || $urandom_range(0, 1) == 1)) begin
                pick          = cand[$urandom_range(0, cand.size() - 1)];
                wb_target     = TW'(pick);
                wb_result     = 32'h1000 + W'(seq);
                mval[pick]    = 32'h1000 + W'(seq);
                written[pick] = 1'b1;
            end
            seq++;
            tick();
            if (acc) begin
                qtag.push_back(mtail);
                mtail = (mtail + 1) % N;
                mcount++;
            end
            if (commit_valid) begin
                chk("rand_commit_nonempty", 64'(qtag.size() > 0), 64'd1);
                if (qtag.size() > 0) begin
                    t = qtag.pop_front();
                    chk("rand_commit_written", 64'(written[t]), 64'd1);
                    chk("rand_cdest", 64'(commit_dest), 64'(mdest[t]));
                    chk("rand_cval",  64'(commit_val),  64'(mval[t]));
                    mcount--;
                end
            end
            chk("rand_full", 64'(full), 64'(mcount == N));
        end
        chk("rand_drained", 64'(qtag.size()), 64'd0);
        chk("rand_wrapped", 64'(seq > N), 64'd1);
        idle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
